alarm_timer: RTL and testbench
==============================

Name: alarm_timer

Overview:
- Consumer side of the time-parameter interface.
- Drives the 2-bit `interval` selector toward the time-parameter block and reads back the 4-bit programmed `value` (seconds).
- Converts the value to a seconds countdown using a clock prescaler and signals expiry to the alarm FSM.
- Sits between the alarm FSM (start/cancel requests) and the parameter store; replaces ad-hoc delay counters in the FSM.

Parameters:
TICKS_PER_SEC, 50000000, clock cycles per one-second tick; must be >= 2.
PRESC_W, 26, prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_SEC.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  1-cycle request to begin a countdown.
start_sel  input  2  interval to read; sampled with start. 00 arm delay, 01 driver door delay, 10 passenger door delay, 11 alarm-on duration.
start_x2  input  1  when 1, the loaded duration is value*2; sampled with start.
cancel  input  1  abort any countdown.
value  input  4  programmed seconds for the currently driven interval (combinational from parameter store).
interval  output  2  registered selector driven to the parameter store.
busy  output  1  high in LOAD and COUNT.
expired  output  1  1-cycle pulse when the countdown reaches zero.
sec_tick  output  1  1-cycle pulse on every counted second (for status LED blink).
remaining  output  5  seconds left; 0 when idle.

Behaviour:
- Reset (asynchronous, reset==0):
  - State goes to IDLE.
  - interval, remaining and the prescaler clear to 0.
  - busy, expired and sec_tick clear to 0.
  - A reset mid-countdown discards the countdown and raises no expired.
- FSM states: IDLE, LOAD, COUNT.
- IDLE:
  - On start at edge k: interval<=start_sel, x2 flag latched, state<=LOAD.
- LOAD (one cycle; interval is stable, so value is valid):
  - At edge k+1: remaining <= start_x2 ? {value,1'b0} : {1'b0,value}; prescaler<=0.
  - If the loaded duration is 0: expired<=1 at edge k+1, state<=IDLE, no ticks.
  - Otherwise state<=COUNT.
- COUNT:
  - The prescaler increments each cycle.
  - When prescaler==TICKS_PER_SEC-1: prescaler<=0, sec_tick<=1, remaining<=remaining-1.
  - If that tick takes remaining from 1 to 0: expired<=1 on the same edge, state<=IDLE.
  - Timing: for duration N, expired is high in the cycle after edge k+1+N*TICKS_PER_SEC.
- value changes while in COUNT (reprogramming) are ignored; value is sampled only in LOAD.
- Retrigger:
  - start in LOAD or COUNT restarts the sequence from the new start_sel/start_x2.
  - This behaves as IDLE-start: next state is LOAD, the prescaler is held at 0, and no expired is produced for the old countdown.
- cancel:
  - In any state, cancel returns the block to IDLE next edge with remaining<=0, prescaler<=0, and no expired or sec_tick.
  - cancel has priority over a simultaneous start.
  - cancel on the same edge as the final tick suppresses expired.
- Output rules:
  - expired and sec_tick are registered pulses, never high more than one cycle.
  - busy is high exactly while the state is LOAD or COUNT.
  - interval holds its last value in IDLE.
- Width: the max duration is 30 s (15*2); remaining never wraps because decrement occurs only when remaining>=1.

Test Plan (TICKS_PER_SEC=4; parameter store model returns 00->3, 01->6, 10->3, 11->0):
1. Hold reset low 3 cycles, then release with start=0 -> interval=0, busy=0, expired=0, sec_tick=0, remaining=0 for 20 cycles.
2. start, start_sel=01 at edge k -> interval=01 from k, remaining=6 after k+1, busy=1, six sec_tick pulses at k+5,k+9,...,k+25, expired pulse after k+25 only, busy=0 after k+25.
3. start, start_sel=10, start_x2=1 -> remaining=6 after LOAD; expired timing identical to scenario 2.
4. start, start_sel=11 (value 0) -> expired pulse after edge k+1, no sec_tick, busy high for exactly one cycle.
5. start_sel=01, then cancel at edge k+12 -> busy=0 and remaining=0 after k+12; no expired for the next 40 cycles. Repeat with cancel and start on the same edge -> block stays IDLE.
6. Two retrigger checks:
   - start_sel=01, then start with start_sel=00 at edge k+10 -> interval=00, remaining=3, expired after k+11+12=k+23 only.
   - start, then change the store's value during COUNT -> countdown unaffected.

Source files
------------

// File: rtl/alarm_timer_if.sv
// Request/status and parameter-store signals of the alarm timer.
// slave: the timer itself; master: alarm FSM plus parameter store.
interface alarm_timer_if;
   logic       start;
   logic [1:0] start_sel;
   logic       start_x2;
   logic       cancel;
   logic [3:0] value;
   logic [1:0] interval;
   logic       busy;
   logic       expired;
   logic       sec_tick;
   logic [4:0] remaining;

   modport master (
      output start, start_sel, start_x2, cancel, value,
      input  interval, busy, expired, sec_tick, remaining
   );

   modport slave (
      input  start, start_sel, start_x2, cancel, value,
      output interval, busy, expired, sec_tick, remaining
   );
endinterface

// File: rtl/alarm_timer.sv
// Seconds countdown for the alarm FSM: selects an interval, loads its value one cycle after start,
// pulses sec_tick each second and expired on reaching zero. No backpressure; cancel beats start.
module alarm_timer #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int PRESC_W       = 26
) (
   input logic         clock,
   input logic         reset,
   alarm_timer_if.slave tif
);

   typedef enum logic [1:0] {IDLE, LOAD, COUNT} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PRESC_W-1:0] presc;
   logic [1:0]         interval_q;
   logic               x2_q;
   logic [4:0]         remaining_q;
   logic               expired_q;
   logic               sec_tick_q;
   logic               busy_c;
   logic [4:0]         load_dur;
   logic               tick_hit;
   logic               last_tick;

   // value is only trusted in LOAD, once interval has been stable for a cycle
   assign load_dur  = x2_q ? {tif.value, 1'b0} : {1'b0, tif.value};
   assign tick_hit  = (state == COUNT) && (presc == PRESC_W'(TICKS_PER_SEC - 1));
   assign last_tick = tick_hit && (remaining_q == 5'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tif.cancel) begin
         state_nxt = IDLE;
      end else if (tif.start) begin
         state_nxt = LOAD;
      end else begin
         case (state)
            LOAD:    state_nxt = (load_dur == 5'd0) ? IDLE : COUNT;
            COUNT:   state_nxt = last_tick ? IDLE : COUNT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy_c = (state != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         interval_q  <= 2'b00;
         x2_q        <= 1'b0;
         remaining_q <= 5'd0;
         presc       <= '0;
         expired_q   <= 1'b0;
         sec_tick_q  <= 1'b0;
      end else begin
         expired_q  <= 1'b0;
         sec_tick_q <= 1'b0;
         if (tif.cancel) begin
            remaining_q <= 5'd0;
            presc       <= '0;
         end else if (tif.start) begin
            // a retrigger drops the old countdown; its pending tick never fires
            interval_q <= tif.start_sel;
            x2_q       <= tif.start_x2;
            presc      <= '0;
         end else begin
            case (state)
               LOAD: begin
                  remaining_q <= load_dur;
                  presc       <= '0;
                  expired_q   <= (load_dur == 5'd0);
               end
               COUNT: begin
                  if (tick_hit) begin
                     presc      <= '0;
                     sec_tick_q <= 1'b1;
                     expired_q  <= last_tick;
                     if (remaining_q != 5'd0) begin
                        remaining_q <= remaining_q - 5'd1;
                     end
                  end else begin
                     presc <= presc + PRESC_W'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign tif.interval  = interval_q;
   assign tif.busy      = busy_c;
   assign tif.expired   = expired_q;
   assign tif.sec_tick  = sec_tick_q;
   assign tif.remaining = remaining_q;

endmodule

// File: tb/tb_alarm_timer.sv
// Directed bench for alarm_timer with a cycle-stamped scoreboard for sec_tick/expired pulses.
module tb_alarm_timer;
   localparam int TPS = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   q_tick[$];
   int   q_exp[$];
   logic [3:0] store [4];

   alarm_timer_if ifc ();

   alarm_timer #(.TICKS_PER_SEC(TPS), .PRESC_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .tif   (ifc)
   );

   assign ifc.value = store[ifc.interval];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pulses are checked against the edge number that produced them.
   always @(negedge clock) begin
      if (reset) begin
         if (ifc.sec_tick) begin
            if (q_tick.size() == 0) chk("sec_tick_unexpected", cyc, -1);
            else chk("sec_tick_time", cyc, q_tick.pop_front());
         end
         if (ifc.expired) begin
            if (q_exp.size() == 0) chk("expired_unexpected", cyc, -1);
            else chk("expired_time", cyc, q_exp.pop_front());
         end
      end
   end

   task automatic flush(input int k);
      int t[$];
      t = {};
      foreach (q_tick[i]) if (q_tick[i] < k) t.push_back(q_tick[i]);
      q_tick = t;
      t = {};
      foreach (q_exp[i]) if (q_exp[i] < k) t.push_back(q_exp[i]);
      q_exp = t;
   endtask

   // Called at a negedge; the request lands on the next rising edge k.
   task automatic issue(input logic [1:0] sel, input logic x2, input logic st,
                        input logic can, input string tag);
      int k;
      int n;
      k = cyc + 1;
      n = x2 ? 2 * int'(store[sel]) : int'(store[sel]);
      flush(k);
      if (st && !can) begin
         if (n == 0) begin
            q_exp.push_back(k + 1);
         end else begin
            for (int i = 1; i <= n; i++) q_tick.push_back(k + 1 + TPS * i);
            q_exp.push_back(k + 1 + TPS * n);
         end
      end
      ifc.start     = st;
      ifc.cancel    = can;
      ifc.start_sel = sel;
      ifc.start_x2  = x2;
      @(negedge clock);
      ifc.start  = 1'b0;
      ifc.cancel = 1'b0;
      ifc.start_x2 = 1'b0;
      if (st && !can) begin
         chk({tag, "_interval"}, int'(ifc.interval), int'(sel));
         chk({tag, "_busy_load"}, int'(ifc.busy), 1);
         @(negedge clock);
         chk({tag, "_remaining_loaded"}, int'(ifc.remaining), n);
         chk({tag, "_busy_after_load"}, int'(ifc.busy), (n != 0) ? 1 : 0);
      end else begin
         chk({tag, "_busy_idle"}, int'(ifc.busy), 0);
         chk({tag, "_remaining_idle"}, int'(ifc.remaining), 0);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((ifc.busy || q_tick.size() != 0 || q_exp.size() != 0) && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_done_in_budget"}, (n < 300) ? 1 : 0, 1);
      chk({tag, "_remaining_end"}, int'(ifc.remaining), 0);
      repeat (3) @(negedge clock);
      q_tick = {};
      q_exp  = {};
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      store[0] = 4'd3; store[1] = 4'd6; store[2] = 4'd3; store[3] = 4'd0;
      ifc.start = 1'b0; ifc.cancel = 1'b0; ifc.start_sel = 2'b00; ifc.start_x2 = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      chk("in_reset_outputs", int'({ifc.interval, ifc.busy, ifc.expired, ifc.sec_tick, ifc.remaining}), 0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("post_reset_outputs", int'({ifc.interval, ifc.busy, ifc.expired, ifc.sec_tick, ifc.remaining}), 0);
      end

      // Plain 6 s countdown
      issue(2'b01, 1'b0, 1'b1, 1'b0, "s2");
      repeat (4) @(negedge clock);
      chk("s2_remaining_after_first_tick", int'(ifc.remaining), 5);
      wait_done("s2");
      chk("s2_interval_held", int'(ifc.interval), 1);

      // Doubled 3 s countdown
      issue(2'b10, 1'b1, 1'b1, 1'b0, "s3");
      wait_done("s3");

      // Zero duration: immediate expiry
      issue(2'b11, 1'b0, 1'b1, 1'b0, "s4");
      wait_done("s4");

      // Cancel mid countdown at k+12
      issue(2'b01, 1'b0, 1'b1, 1'b0, "s5");
      repeat (10) @(negedge clock);
      issue(2'b01, 1'b0, 1'b0, 1'b1, "s5_cancel");
      repeat (40) @(negedge clock);
      chk("s5_no_pending", q_tick.size() + q_exp.size(), 0);

      // Cancel and start together: cancel wins
      issue(2'b00, 1'b0, 1'b1, 1'b1, "s5b");
      repeat (20) @(negedge clock);
      chk("s5b_still_idle", int'(ifc.busy), 0);

      // Retrigger at k+10 with a shorter interval
      issue(2'b01, 1'b0, 1'b1, 1'b0, "s6a");
      repeat (8) @(negedge clock);
      issue(2'b00, 1'b0, 1'b1, 1'b0, "s6a_retrig");
      wait_done("s6a");

      // Reprogramming the store during COUNT has no effect
      issue(2'b00, 1'b0, 1'b1, 1'b0, "s6b");
      repeat (3) @(negedge clock);
      store[0] = 4'd9;
      repeat (2) @(negedge clock);
      chk("s6b_remaining_unchanged", int'(ifc.remaining), 2);
      wait_done("s6b");
      store[0] = 4'd3;

      // Reset mid countdown discards it silently
      issue(2'b01, 1'b0, 1'b1, 1'b0, "s7");
      repeat (6) @(negedge clock);
      reset = 1'b0;
      q_tick = {};
      q_exp  = {};
      @(negedge clock);
      chk("s7_reset_outputs", int'({ifc.interval, ifc.busy, ifc.expired, ifc.sec_tick, ifc.remaining}), 0);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      chk("s7_idle_after_reset", int'({ifc.busy, ifc.remaining}), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
